// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed seven-segment scanner with double-buffered display data,
// per-digit blanking, blinking, and hex or lock-status glyph sets.
module sevseg_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  input  logic                    glyph_mode,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic [NUM_DIGITS-1:0]   anode,
  output logic [6:0]              seg_out,
  output logic                    frame_done
);

  localparam int SW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(NUM_DIGITS);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] INDEX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [SW:0]   BLANK_END  = (SW+1)'(BLANK_CYCLES);

  logic [SW-1:0]           slotCnt;
  logic [IW-1:0]           digitIdx;
  logic [FW-1:0]           frameCnt;
  logic                    blinkPhase;

  logic [4*NUM_DIGITS-1:0] activeData, pendingData;
  logic                    activeMode, pendingMode;
  logic [NUM_DIGITS-1:0]   activeEn, pendingEn;
  logic [NUM_DIGITS-1:0]   activeMask, pendingMask;
  logic                    pendingValid;

  logic                    slotWrap, frameWrap, pastBlank, litNow;
  logic [SW:0]             slotPlusOne;
  logic [3:0]              curNibble;
  logic                    curEn, curMask;
  logic [NUM_DIGITS-1:0]   anodeNext;
  logic [6:0]              segNext;

  function automatic logic [6:0] glyphOf(input logic [3:0] nib, input logic statusMode);
    logic [6:0] g;
    g = 7'b1000111;
    if (statusMode) begin
      case (nib)
        4'h1:    g = 7'b1000001;
        4'h2:    g = 7'b0001001;
        default: g = 7'b1000111;
      endcase
    end else begin
      case (nib)
        4'h0: g = 7'b1000000;  4'h1: g = 7'b1111001;
        4'h2: g = 7'b0100100;  4'h3: g = 7'b0110000;
        4'h4: g = 7'b0011001;  4'h5: g = 7'b0010010;
        4'h6: g = 7'b0000010;  4'h7: g = 7'b1111000;
        4'h8: g = 7'b0000000;  4'h9: g = 7'b0010000;
        4'hA: g = 7'b0001000;  4'hB: g = 7'b0000011;
        4'hC: g = 7'b1000110;  4'hD: g = 7'b0100001;
        4'hE: g = 7'b0000110;  default: g = 7'b0001110;
      endcase
    end
    return g;
  endfunction

  // Comparing slotCnt+1 against BLANK_CYCLES keeps the test meaningful when BLANK_CYCLES is 0.
  always_comb begin
    slotWrap    = (slotCnt == SLOT_LAST);
    frameWrap   = slotWrap && (digitIdx == INDEX_LAST);
    slotPlusOne = {1'b0, slotCnt} + 1'b1;
    pastBlank   = (slotPlusOne > BLANK_END);
    curNibble   = 4'h0;
    curEn       = 1'b0;
    curMask     = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digitIdx == IW'(i)) begin
        curNibble = activeData[4*i +: 4];
        curEn     = activeEn[i];
        curMask   = activeMask[i];
      end
    end
    litNow = pastBlank && curEn && !(curMask && blinkPhase);
    for (int i = 0; i < NUM_DIGITS; i++) begin
      anodeNext[i] = !(litNow && (digitIdx == IW'(i)));
    end
    segNext = litNow ? glyphOf(curNibble, activeMode) : 7'b1111111;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotCnt    <= '0;
      digitIdx   <= '0;
      frameCnt   <= '0;
      blinkPhase <= 1'b0;
      anode      <= '1;
      seg_out    <= 7'b1111111;
      frame_done <= 1'b0;
    end else begin
      anode      <= anodeNext;
      seg_out    <= segNext;
      frame_done <= frameWrap;
      if (slotWrap) begin
        slotCnt  <= '0;
        digitIdx <= (digitIdx == INDEX_LAST) ? '0 : digitIdx + 1'b1;
      end else begin
        slotCnt  <= slotCnt + 1'b1;
      end
      if (frameWrap) begin
        if (frameCnt == FRAME_LAST) begin
          frameCnt   <= '0;
          blinkPhase <= !blinkPhase;
        end else begin
          frameCnt   <= frameCnt + 1'b1;
        end
      end
    end
  end

  // Active data only changes on the frame boundary so a frame never tears;
  // a load landing on that boundary bypasses (and discards) the pending copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      activeData   <= '0;
      activeMode   <= 1'b0;
      activeEn     <= '0;
      activeMask   <= '0;
      pendingData  <= '0;
      pendingMode  <= 1'b0;
      pendingEn    <= '0;
      pendingMask  <= '0;
      pendingValid <= 1'b0;
    end else if (frameWrap) begin
      pendingValid <= 1'b0;
      if (load) begin
        activeData <= digit_data;
        activeMode <= glyph_mode;
        activeEn   <= digit_en;
        activeMask <= blink_mask;
      end else if (pendingValid) begin
        activeData <= pendingData;
        activeMode <= pendingMode;
        activeEn   <= pendingEn;
        activeMask <= pendingMask;
      end
    end else if (load) begin
      pendingData  <= digit_data;
      pendingMode  <= glyph_mode;
      pendingEn    <= digit_en;
      pendingMask  <= blink_mask;
      pendingValid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed bench for sevseg_scan_driver with a 4-digit, 4-clock-slot configuration;
// each frame is 16 cycles, captured and compared against a small scan model.
module tb_sevseg_scan_driver;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [15:0] digit_data;
  logic        glyph_mode;
  logic [3:0]  digit_en;
  logic [3:0]  blink_mask;
  logic [3:0]  anode;
  logic [6:0]  seg_out;
  logic        frame_done;

  int total = 0;
  int bad = 0;
  int frameCount = 0;
  logic monOn = 1'b0;

  logic [3:0] capA  [1:16];
  logic [6:0] capS  [1:16];
  logic       capFd [1:16];

  logic [6:0] hexTab [0:15] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                                7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  sevseg_scan_driver #(
    .NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .digit_data(digit_data),
    .glyph_mode(glyph_mode), .digit_en(digit_en), .blink_mask(blink_mask),
    .anode(anode), .seg_out(seg_out), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts frames since reset and watches the one-anode / blank-cathode invariants every cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      frameCount = 0;
    end else begin
      if (frame_done === 1'b1) frameCount++;
      if (monOn) begin
        total++;
        if ($countones(~anode) > 1 || (anode === 4'hF && seg_out !== 7'h7F)) begin
          bad++;
          $display("[TB] FAIL invariant anode=%b seg=%b required at most one low anode and blank seg when idle", anode, seg_out);
        end
      end
    end
  end

  function automatic logic [6:0] tbGlyph(input logic [3:0] n, input logic m);
    if (!m) return hexTab[n];
    if (n == 4'h1) return 7'b1000001;
    if (n == 4'h2) return 7'b0001001;
    return 7'b1000111;
  endfunction

  // Cycle k of a frame (1..16 after the frame_done cycle): digit d lit on k = 4d+2..4d+4.
  function automatic void expAt(input int k, input logic [15:0] data, input logic mode,
                                input logic [3:0] en, input logic [3:0] mask, input logic phase,
                                output logic [3:0] a, output logic [6:0] s);
    int d;
    a = 4'hF;
    s = 7'h7F;
    if (k % 4 != 1) begin
      d = (k - 2) / 4;
      if (en[d] && !(mask[d] && phase)) begin
        a[d] = 1'b0;
        s = tbGlyph(data[4*d +: 4], mode);
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [15:0] data, input logic mode,
                               input logic [3:0] en, input logic [3:0] mask);
    digit_data = data;
    glyph_mode = mode;
    digit_en   = en;
    blink_mask = mask;
    load       = 1'b1;
    tick();
    load       = 1'b0;
  endtask

  task automatic waitFrame(output logic found);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      tick();
      if (frame_done === 1'b1) found = 1'b1;
    end
  endtask

  task automatic captureFrame();
    for (int k = 1; k <= 16; k++) begin
      tick();
      capA[k]  = anode;
      capS[k]  = seg_out;
      capFd[k] = frame_done;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    load = 1'b0;
    digit_data = '0;
    glyph_mode = 1'b0;
    digit_en = '0;
    blink_mask = '0;
    #3 rst_n = 1'b0;
    #2;
    monOn = 1'b1;
    total++;
    if (anode !== 4'hF) begin bad++; $display("[TB] FAIL reset_anode got=%b want=1111", anode); end
    total++;
    if (seg_out !== 7'h7F) begin bad++; $display("[TB] FAIL reset_seg got=%b want=1111111", seg_out); end
    total++;
    if (frame_done !== 1'b0) begin bad++; $display("[TB] FAIL reset_frame_done got=%b want=0", frame_done); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_hex();
    logic [3:0] ea;
    logic [6:0] es;
    int seenAt;
    logic blankOk;
    tick();
    applyStimulus(16'h3A51, 1'b0, 4'hF, 4'h0);
    seenAt = 0;
    blankOk = 1'b1;
    for (int e = 3; e <= 40 && seenAt == 0; e++) begin
      tick();
      if (anode !== 4'hF || seg_out !== 7'h7F) blankOk = 1'b0;
      if (frame_done === 1'b1) seenAt = e;
    end
    total++;
    if (!blankOk) begin bad++; $display("[TB] FAIL preload_blank lit output seen before first frame boundary"); end
    total++;
    if (seenAt != 16) begin bad++; $display("[TB] FAIL first_frame_done got cycle=%0d want=16", seenAt); end
    captureFrame();
    for (int k = 1; k <= 16; k++) begin
      expAt(k, 16'h3A51, 1'b0, 4'hF, 4'h0, 1'b0, ea, es);
      total++;
      if (capA[k] !== ea || capS[k] !== es) begin
        bad++;
        $display("[TB] FAIL hex_frame k=%0d anode=%b seg=%b want anode=%b seg=%b", k, capA[k], capS[k], ea, es);
      end
    end
    total++;
    if (capFd[16] !== 1'b1 || capFd[8] !== 1'b0 || capFd[15] !== 1'b0) begin
      bad++;
      $display("[TB] FAIL frame_period fd8=%b fd15=%b fd16=%b want 0 0 1", capFd[8], capFd[15], capFd[16]);
    end
  endtask

  task automatic test_status();
    logic [3:0] ea;
    logic [6:0] es;
    logic found;
    logic [15:0] patterns [0:1] = '{16'h0210, 16'h2517};
    for (int p = 0; p < 2; p++) begin
      applyStimulus(patterns[p], 1'b1, 4'hF, 4'h0);
      waitFrame(found);
      total++;
      if (!found) begin bad++; $display("[TB] FAIL status_wait frame_done not seen got=0 want=1"); end
      captureFrame();
      for (int k = 1; k <= 16; k++) begin
        expAt(k, patterns[p], 1'b1, 4'hF, 4'h0, 1'b0, ea, es);
        total++;
        if (capA[k] !== ea || capS[k] !== es) begin
          bad++;
          $display("[TB] FAIL status_frame data=%h k=%0d anode=%b seg=%b want anode=%b seg=%b", patterns[p], k, capA[k], capS[k], ea, es);
        end
      end
    end
  endtask

  task automatic test_enable();
    logic [3:0] ea;
    logic [6:0] es;
    logic found;
    applyStimulus(16'h8888, 1'b0, 4'b0101, 4'h0);
    waitFrame(found);
    total++;
    if (!found) begin bad++; $display("[TB] FAIL enable_wait frame_done not seen got=0 want=1"); end
    captureFrame();
    for (int k = 1; k <= 16; k++) begin
      expAt(k, 16'h8888, 1'b0, 4'b0101, 4'h0, 1'b0, ea, es);
      total++;
      if (capA[k] !== ea || capS[k] !== es) begin
        bad++;
        $display("[TB] FAIL enable_frame k=%0d anode=%b seg=%b want anode=%b seg=%b", k, capA[k], capS[k], ea, es);
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] ea;
    logic [6:0] es;
    logic found;
    logic phase;
    int n;
    applyStimulus(16'h1234, 1'b0, 4'hF, 4'b0001);
    waitFrame(found);
    total++;
    if (!found) begin bad++; $display("[TB] FAIL blink_wait frame_done not seen got=0 want=1"); end
    for (int f = 0; f < 4; f++) begin
      n = frameCount + 1;
      phase = ((n / 2) % 2) == 1;
      captureFrame();
      for (int k = 1; k <= 16; k++) begin
        expAt(k, 16'h1234, 1'b0, 4'hF, 4'b0001, phase, ea, es);
        total++;
        if (capA[k] !== ea || capS[k] !== es) begin
          bad++;
          $display("[TB] FAIL blink_frame n=%0d k=%0d anode=%b seg=%b want anode=%b seg=%b", n, k, capA[k], capS[k], ea, es);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] ea;
    logic [6:0] es;
    repeat (2) tick();
    applyStimulus(16'h1111, 1'b0, 4'hF, 4'h0);
    repeat (2) tick();
    applyStimulus(16'h2222, 1'b0, 4'hF, 4'h0);
    repeat (10) tick();
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL b2b_boundary frame_done got=%b want=1", frame_done); end
    captureFrame();
    for (int k = 1; k <= 16; k++) begin
      expAt(k, 16'h2222, 1'b0, 4'hF, 4'h0, 1'b0, ea, es);
      total++;
      if (capA[k] !== ea || capS[k] !== es) begin
        bad++;
        $display("[TB] FAIL last_load_wins k=%0d anode=%b seg=%b want anode=%b seg=%b", k, capA[k], capS[k], ea, es);
      end
    end
    repeat (5) tick();
    applyStimulus(16'h9999, 1'b0, 4'hF, 4'h0);
    repeat (9) tick();
    applyStimulus(16'h7777, 1'b0, 4'hF, 4'h0);
    total++;
    if (frame_done !== 1'b1) begin bad++; $display("[TB] FAIL boundary_load_alignment frame_done got=%b want=1", frame_done); end
    for (int f = 0; f < 2; f++) begin
      captureFrame();
      for (int k = 1; k <= 16; k++) begin
        expAt(k, 16'h7777, 1'b0, 4'hF, 4'h0, 1'b0, ea, es);
        total++;
        if (capA[k] !== ea || capS[k] !== es) begin
          bad++;
          $display("[TB] FAIL boundary_load frame=%0d k=%0d anode=%b seg=%b want anode=%b seg=%b", f, k, capA[k], capS[k], ea, es);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    logic fdOk;
    logic blankOk;
    repeat (11) tick();
    total++;
    if (anode !== 4'b1011 || seg_out !== 7'b1111000) begin
      bad++;
      $display("[TB] FAIL pre_reset_digit2 anode=%b seg=%b want anode=1011 seg=1111000", anode, seg_out);
    end
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (anode !== 4'hF || seg_out !== 7'h7F || frame_done !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset_immediate anode=%b seg=%b fd=%b want 1111 1111111 0", anode, seg_out, frame_done);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    fdOk = 1'b1;
    blankOk = 1'b1;
    for (int e = 1; e <= 16; e++) begin
      tick();
      if (anode !== 4'hF || seg_out !== 7'h7F) blankOk = 1'b0;
      if (frame_done !== (e == 16)) fdOk = 1'b0;
    end
    total++;
    if (!blankOk) begin bad++; $display("[TB] FAIL post_reset_blank lit output got=lit want=blank"); end
    total++;
    if (!fdOk) begin bad++; $display("[TB] FAIL post_reset_restart frame_done not exactly at cycle 16 after release"); end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_status();
    test_enable();
    test_blink();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevseg_scan_driver.md
Name: sevseg_scan_driver

Overview:
- Parametrised time-multiplexed seven-segment driver for the combo-lock board.
- Successor to the single-digit combinational decoder: drives NUM_DIGITS digits by scanning, with per-digit blanking and blinking.
- Offers two glyph modes: hex digits, and lock-status glyphs (L/U/H).
- Sits between the lock FSM/decoder and the board anode/cathode pins. Display data is double-buffered so updates never tear mid-frame.

Parameters:
- NUM_DIGITS, 4: number of digits scanned; anode width; range 2..8.
- REFRESH_DIV, 100000: clocks per digit slot; must be at least BLANK_CYCLES+2.
- BLANK_CYCLES, 2: dead-time clocks at the start of each slot with all anodes off (anti-ghosting); may be 0.
- BLINK_FRAMES, 64: full frames per blink half-period; must be at least 1.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset.
- load  in  1  one-cycle strobe; captures digit_data, glyph_mode, digit_en and blink_mask into the pending buffer.
- digit_data  in  4*NUM_DIGITS  nibble i drives digit i; digit 0 is the rightmost.
- glyph_mode  in  1  0 = hex glyphs, 1 = lock-status glyphs.
- digit_en  in  NUM_DIGITS  1 = digit enabled, 0 = permanently blanked.
- blink_mask  in  NUM_DIGITS  1 = digit blanked during the blink-off phase.
- anode  out  NUM_DIGITS  active-low digit enables.
- seg_out  out  7  active-low cathodes, bit order {g,f,e,d,c,b,a}.
- frame_done  out  1  one-cycle pulse when the scan wraps from the last digit to digit 0.

Interface (already decided): one clock (clk); reset rst_n is asynchronous and active-low.

Behaviour:
- Reset (rst_n low, asynchronous) clears all state, independent of clk:
  - anode = all 1s, seg_out = 7'b1111111, frame_done = 0.
  - slot counter = 0, digit index = 0, frame counter = 0, blink_phase = 0 (blink-on).
  - Active and pending buffers = 0; pending_valid = 0.
  - Deasserting reset mid-scan restarts cleanly at digit 0, count 0.
- Slot counter counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the digit index increments.
  - The index wraps from NUM_DIGITS-1 to 0. That wrap cycle is the frame boundary.
- Frame boundary, all in the same clock edge:
  - frame_done pulses high for exactly 1 cycle, registered.
  - If pending_valid, pending copies to active and pending_valid clears.
  - Frame counter increments. At BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles.
- load outside the frame-boundary cycle: inputs are captured into pending and pending_valid sets. A later load before the boundary overwrites pending (last wins).
- load on the frame-boundary cycle: inputs go directly into active (load wins over any stale pending), and pending_valid clears.
- Digit i is lit when all of the following hold: index == i, slot count >= BLANK_CYCLES, active digit_en[i] = 1, and NOT (active blink_mask[i] = 1 AND blink_phase = 1).
- Outputs are registered, with 1-cycle latency from the counter/index state:
  - Lit: anode = all 1s except bit i = 0; seg_out = glyph of active nibble i.
  - Not lit: anode = all 1s and seg_out = 7'b1111111.
  - At most one anode bit is ever low.
- Hex glyphs (glyph_mode 0), 0..F:
  1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000, 0001000, 0000011, 1000110, 0100001, 0000110, 0001110.
- Status glyphs (glyph_mode 1):
  - 0 = L 1000111.
  - 1 = U 1000001.
  - 2 = H 0001001.
  - 3..F = L 1000111.
- glyph_mode is frame-wide. It is taken from the active buffer, never live.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, BLINK_FRAMES=2):
1. Reset then release; load data=16'h3A51, mode 0, en=4'hF, mask=0.
   - The load is not visible until the first frame_done.
   - Next frame: digit0 anode=1110, seg=1111001; d1=0010010; d2=0001000; d3=0110000.
   - Each digit is lit for 3 cycles after 1 blank cycle.
   - frame_done pulses every 16 cycles.
2. mode 1, data=16'h0210, en=4'hF.
   - Frame shows d0=L 1000111, d1=U 1000001, d2=H 0001001, d3=L.
   - Nibble 5 in any position displays L.
3. en=4'b0101.
   - Slots 1 and 3 keep anode=1111, seg=1111111.
   - At no cycle is more than one anode bit low, and seg is never non-blank while anode=1111.
4. mask=4'b0001.
   - d0 is visible for 2 frames, blank for 2 frames, and so on.
   - d1..d3 are never blanked by blink.
5. Two loads mid-frame (0x1111 then 0x2222): the next frame shows 2s only. A load on the exact frame_done cycle is displayed in the frame starting at that edge.
6. Assert rst_n low mid-slot on digit 2 (async, between clk edges).
   - Outputs go to 1111/1111111 immediately.
   - After release, the scan restarts at digit 0 and the active buffer reads 0 (no digits lit until the next load).
